// File: rtl/ram_pkg.sv
// Shared types, constants and helpers for the dual-port synchronous RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  localparam int unsigned RDW_OLD     = 0;
  localparam int unsigned RDW_NEW     = 1;
  localparam int unsigned MERGE_WIDTH = 256;

  // Replace the bits of old_word selected by bit_mask with new_word.
  function automatic logic [MERGE_WIDTH-1:0] lane_merge(
    input logic [MERGE_WIDTH-1:0] old_word,
    input logic [MERGE_WIDTH-1:0] new_word,
    input logic [MERGE_WIDTH-1:0] bit_mask
  );
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/ram_dp_sync_if.sv
// Request/response bundle of the dual-port RAM: write port, read port and status.
interface ram_dp_sync_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] address_write;
  logic [DATA_WIDTH-1:0] data_write;
  logic [NBYTES-1:0]     byte_enable;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] address_read;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  read_valid;
  logic                  busy;

  modport master (
    output write_enable, address_write, data_write, byte_enable,
    output read_enable, address_read,
    input  data_read, read_valid, busy
  );

  modport slave (
    input  write_enable, address_write, data_write, byte_enable,
    input  read_enable, address_read,
    output data_read, read_valid, busy
  );

endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: owns the CLEAR/RUN FSM, clear counter, busy flag and
// selects between the clear walker and user requests for the array write port.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NBYTES         = 1,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address_write,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic [NBYTES-1:0]     byte_enable,
  input  logic                  read_enable,
  output logic                  busy,
  output logic                  mem_we_c,
  output logic [ADDR_WIDTH-1:0] mem_addr_c,
  output logic [DATA_WIDTH-1:0] mem_data_c,
  output logic [NBYTES-1:0]     mem_lanes_c,
  output logic                  read_en_c
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  ram_state_t            state;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt   <= '0;
      busy  <= (CLEAR_ON_RESET != 0);
    end else if (state == CLEAR) begin
      cnt <= cnt + ADDR_WIDTH'(1);
      if (cnt == LAST_ADDR) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end
  end

  // Clear walker owns the write port while clearing; requests in a reset cycle are dropped.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = address_write;
    mem_data_c  = data_write;
    mem_lanes_c = byte_enable;
    read_en_c   = 1'b0;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = cnt;
        mem_data_c  = '0;
        mem_lanes_c = '1;
      end else begin
        mem_we_c  = write_enable && ({1'b0, address_write} < DEPTH_LIM) && (|byte_enable);
        read_en_c = read_enable;
      end
    end
  end

endmodule

// File: rtl/ram_dp_sync.sv
// Simple dual-port synchronous RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and optional post-reset clear.
module ram_dp_sync
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic          clk,
  input logic          reset,
  ram_dp_sync_if.slave bus
);

  localparam int unsigned         NBYTES    = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH > MERGE_WIDTH) begin : g_bad_merge
    $error("DATA_WIDTH exceeds lane_merge width");
  end

  logic                  busy;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_data_c;
  logic [NBYTES-1:0]     mem_lanes_c;
  logic                  read_en_c;
  logic [DATA_WIDTH-1:0] wr_bits_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_clear_seq #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NBYTES         (NBYTES),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk           (clk),
    .reset         (reset),
    .write_enable  (bus.write_enable),
    .address_write (bus.address_write),
    .data_write    (bus.data_write),
    .byte_enable   (bus.byte_enable),
    .read_enable   (bus.read_enable),
    .busy          (busy),
    .mem_we_c      (mem_we_c),
    .mem_addr_c    (mem_addr_c),
    .mem_data_c    (mem_data_c),
    .mem_lanes_c   (mem_lanes_c),
    .read_en_c     (read_en_c)
  );

  always_comb begin
    wr_bits_c = '0;
    for (int unsigned l = 0; l < NBYTES; l++) begin
      wr_bits_c[l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{mem_lanes_c[l]}};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned l = 0; l < NBYTES; l++) begin
        if (mem_lanes_c[l]) begin
          mem[mem_addr_c][l*BYTE_WIDTH +: BYTE_WIDTH] <= mem_data_c[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Out-of-range reads return zero; in new-data mode a same-address write is forwarded.
  always_comb begin
    rd_word_c = '0;
    if ({1'b0, bus.address_read} < DEPTH_LIM) begin
      rd_word_c = mem[bus.address_read];
    end
    if (RDW_MODE == RDW_NEW && mem_we_c && mem_addr_c == bus.address_read) begin
      rd_word_c = DATA_WIDTH'(lane_merge(MERGE_WIDTH'(rd_word_c), MERGE_WIDTH'(mem_data_c),
                                         MERGE_WIDTH'(wr_bits_c)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= read_en_c;
      if (read_en_c) s1_data <= rd_word_c;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign bus.data_read  = s2_data;
    assign bus.read_valid = s2_valid;
  end else begin : g_lat1
    assign bus.data_read  = s1_data;
    assign bus.read_valid = s1_valid;
  end

  assign bus.busy = busy;

endmodule
